// File: rtl/load_hazard_pipe_if.sv
// Bundle between the EX/MEM/WB pipeline registers and the decode-stage forwarding logic.
// The LOAD_HAZARD_STATS_EN macro adds the stall_cycles statistics signal.
interface load_hazard_pipe_if;
  logic        ex_valid;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [31:0] ex_result;
  logic [31:0] mem_load_data;
  logic        flush;
  logic [31:0] id_instruction;

  logic [4:0]  destMEM;
  logic        regWriteMEM;
  logic [31:0] ALURESULTMEM;
  logic [4:0]  destWB;
  logic        regWriteWB;
  logic [31:0] ALURESULTWB;
  logic        stall_id;
  logic        bubble_ex;
  logic        stall_err;
`ifdef LOAD_HAZARD_STATS_EN
  logic [31:0] stall_cycles;

  modport master (
    output ex_valid, ex_dest, ex_regwrite, ex_memread, ex_result,
           mem_load_data, flush, id_instruction,
    input  destMEM, regWriteMEM, ALURESULTMEM, destWB, regWriteWB, ALURESULTWB,
           stall_id, bubble_ex, stall_err, stall_cycles
  );
  modport slave (
    input  ex_valid, ex_dest, ex_regwrite, ex_memread, ex_result,
           mem_load_data, flush, id_instruction,
    output destMEM, regWriteMEM, ALURESULTMEM, destWB, regWriteWB, ALURESULTWB,
           stall_id, bubble_ex, stall_err, stall_cycles
  );
`else
  modport master (
    output ex_valid, ex_dest, ex_regwrite, ex_memread, ex_result,
           mem_load_data, flush, id_instruction,
    input  destMEM, regWriteMEM, ALURESULTMEM, destWB, regWriteWB, ALURESULTWB,
           stall_id, bubble_ex, stall_err
  );
  modport slave (
    input  ex_valid, ex_dest, ex_regwrite, ex_memread, ex_result,
           mem_load_data, flush, id_instruction,
    output destMEM, regWriteMEM, ALURESULTMEM, destWB, regWriteWB, ALURESULTWB,
           stall_id, bubble_ex, stall_err
  );
`endif
endinterface

// File: rtl/load_hazard_pipe.sv
// Producer side of operand forwarding: MEM/WB result slots plus load-use stall detection.
// Optional LOAD_HAZARD_STATS_EN adds a saturating stall-cycle counter.
module load_hazard_pipe #(
  parameter int MAX_STALL = 4
) (
  input logic               Clk,
  input logic               Rst,
  load_hazard_pipe_if.slave bus
);
  localparam logic [0:0]  ST_RUN  = 1'b0;
  localparam logic [0:0]  ST_WAIT = 1'b1;
  localparam logic [31:0] MAX_STALL_U = 32'(MAX_STALL);

  logic        slot_valid;
  logic [4:0]  mem_dest, wb_dest;
  logic        mem_regwrite, mem_memread, wb_regwrite;
  logic [31:0] mem_result, wb_result;

  assign slot_valid = bus.ex_valid & ~bus.flush;

  // Slots advance every cycle; a stall only inserts a bubble behind them.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_dest     <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_result   <= '0;
      wb_dest      <= '0;
      wb_regwrite  <= 1'b0;
      wb_result    <= '0;
    end else begin
      // NOTE: non-blocking assignments let the WB slot read the old MEM slot in the same edge.
      mem_dest     <= bus.ex_dest;
      mem_regwrite <= bus.ex_regwrite & slot_valid & (bus.ex_dest != 5'd0);
      mem_memread  <= bus.ex_memread & slot_valid;
      mem_result   <= bus.ex_result;
      wb_dest      <= mem_dest;
      wb_regwrite  <= mem_regwrite;
      wb_result    <= mem_memread ? bus.mem_load_data : mem_result;
    end
  end

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       read_rs, read_rt;
  logic       ex_pending, mem_pending, hazard;
  logic       unused_id_bits;

  assign op             = bus.id_instruction[31:26];
  assign rs             = bus.id_instruction[25:21];
  assign rt             = bus.id_instruction[20:16];
  assign unused_id_bits = ^bus.id_instruction[15:0];
  assign read_rs = !(op inside {6'b000010, 6'b000011, 6'b001111});
  assign read_rt = op inside {6'b000000, 6'b011100, 6'b101011, 6'b101000,
                              6'b101001, 6'b000100, 6'b000101};

  function automatic logic reads_reg(input logic [4:0] dest, input logic [4:0] s,
                                     input logic [4:0] t, input logic use_s,
                                     input logic use_t);
    return (dest != 5'd0) && ((use_s && s == dest) || (use_t && t == dest));
  endfunction

  assign ex_pending  = slot_valid & bus.ex_memread & bus.ex_regwrite &
                       reads_reg(bus.ex_dest, rs, rt, read_rs, read_rt);
  assign mem_pending = mem_memread & mem_regwrite &
                       reads_reg(mem_dest, rs, rt, read_rs, read_rt);
  // Gated by Rst so the stall drops the instant reset asserts.
  assign hazard      = ~Rst & (ex_pending | mem_pending);

  logic [0:0] state, state_nxt;
  logic [2:0] run_cnt, run_cnt_nxt;
  logic       stall_err_q;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    case (state)
      ST_RUN: begin
        if (hazard) begin
          state_nxt   = ST_WAIT;
          run_cnt_nxt = 3'd1;
        end else begin
          run_cnt_nxt = 3'd0;
        end
      end
      ST_WAIT: begin
        if (hazard) begin
          if (run_cnt != 3'd7) run_cnt_nxt = run_cnt + 3'd1;
        end else begin
          state_nxt   = ST_RUN;
          run_cnt_nxt = 3'd0;
        end
      end
      default: begin
        state_nxt   = ST_RUN;
        run_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= ST_RUN;
      run_cnt     <= 3'd0;
      stall_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      run_cnt     <= run_cnt_nxt;
      stall_err_q <= stall_err_q | (32'(run_cnt_nxt) > MAX_STALL_U);
    end
  end

`ifdef LOAD_HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                              stall_cnt <= '0;
    else if (hazard && stall_cnt != '1)   stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
`endif

  assign bus.destMEM      = mem_dest;
  assign bus.regWriteMEM  = mem_regwrite;
  assign bus.ALURESULTMEM = mem_result;
  assign bus.destWB       = wb_dest;
  assign bus.regWriteWB   = wb_regwrite;
  assign bus.ALURESULTWB  = wb_result;
  assign bus.stall_id     = hazard;
  assign bus.bubble_ex    = hazard;
  assign bus.stall_err    = stall_err_q;
endmodule

// File: tb/tb_load_hazard_pipe.sv
// Directed bench for load_hazard_pipe: decode/stall vector table plus multi-cycle sequences.
module tb_load_hazard_pipe;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  load_hazard_pipe_if bus ();
  load_hazard_pipe #(.MAX_STALL(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h5020};
  endfunction

  task automatic set_ex(input logic v, input logic [4:0] d, input logic rw, input logic mr,
                        input logic fl, input logic [31:0] res);
    bus.ex_valid    = v;
    bus.ex_dest     = d;
    bus.ex_regwrite = rw;
    bus.ex_memread  = mr;
    bus.flush       = fl;
    bus.ex_result   = res;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    #2;
    Rst = 1'b0;
  endtask

  typedef struct {
    logic        pre_load;
    logic [4:0]  pre_dest;
    logic        v;
    logic [4:0]  d;
    logic        rw;
    logic        mr;
    logic        fl;
    logic [31:0] id;
    logic        exp_stall;
    logic        exp_rw_mem;
  } vec_t;

  vec_t vecs[15];
  int   stalls;

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  1, 5'd9, 1, 1, 0, instr(6'b000000, 5'd9, 5'd0),  1'b1, 1'b1};
    vecs[1]  = '{1'b0, 5'd0,  1, 5'd9, 1, 1, 0, instr(6'b000000, 5'd0, 5'd9),  1'b1, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  1, 5'd0, 1, 1, 0, instr(6'b000000, 5'd0, 5'd0),  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  1, 5'd9, 1, 1, 1, instr(6'b000000, 5'd9, 5'd0),  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  1, 5'd9, 1, 0, 0, instr(6'b000000, 5'd9, 5'd0),  1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'd9,  0, 5'd0, 0, 0, 0, instr(6'b000000, 5'd9, 5'd0),  1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd9,  1, 5'd9, 1, 1, 1, instr(6'b000000, 5'd9, 5'd0),  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd11, 0, 5'd0, 0, 0, 0, instr(6'b101011, 5'd2, 5'd11), 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd11, 0, 5'd0, 0, 0, 0, instr(6'b001000, 5'd2, 5'd11), 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  1, 5'd9, 1, 1, 0, instr(6'b000010, 5'd9, 5'd9),  1'b0, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  1, 5'd9, 1, 1, 0, instr(6'b001111, 5'd9, 5'd0),  1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  1, 5'd9, 1, 1, 0, instr(6'b000100, 5'd0, 5'd9),  1'b1, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  1, 5'd9, 0, 1, 0, instr(6'b000000, 5'd9, 5'd0),  1'b0, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  0, 5'd9, 1, 1, 0, instr(6'b000000, 5'd9, 5'd0),  1'b0, 1'b0};
    vecs[14] = '{1'b1, 5'd9,  0, 5'd0, 0, 0, 0, instr(6'b011100, 5'd0, 5'd9),  1'b1, 1'b0};

    set_ex(0, 5'd0, 0, 0, 0, 32'h0);
    bus.id_instruction = 32'h0;
    bus.mem_load_data  = 32'hDEAD_BEEF;
    #3;
    check("reset_stall_id",  bus.stall_id,    32'h0);
    check("reset_stall_err", bus.stall_err,   32'h0);
    check("reset_dest_mem",  bus.destMEM,     32'h0);
    check("reset_result_wb", bus.ALURESULTWB, 32'h0);
    Rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      do_reset();
      set_ex(0, 5'd0, 0, 0, 0, 32'h0);
      bus.id_instruction = 32'h0;
      if (vecs[i].pre_load) set_ex(1, vecs[i].pre_dest, 1, 1, 0, 32'h40);
      tick();
      set_ex(vecs[i].v, vecs[i].d, vecs[i].rw, vecs[i].mr, vecs[i].fl, 32'h80);
      bus.id_instruction = vecs[i].id;
      #1;
      check($sformatf("vec%0d_stall_id", i),  bus.stall_id,  {31'b0, vecs[i].exp_stall});
      check($sformatf("vec%0d_bubble_ex", i), bus.bubble_ex, {31'b0, vecs[i].exp_stall});
      tick();
      check($sformatf("vec%0d_regwrite_mem", i), bus.regWriteMEM, {31'b0, vecs[i].exp_rw_mem});
    end

    // ALU producer: forwards without stalling, 1 and 2 cycle latencies.
    do_reset();
    bus.mem_load_data  = 32'h1234_5678;
    set_ex(1, 5'd8, 1, 0, 0, 32'h0000_0010);
    bus.id_instruction = instr(6'b000000, 5'd8, 5'd0);
    #1;
    check("alu_stall_id", bus.stall_id, 32'h0);
    tick();
    set_ex(0, 5'd0, 0, 0, 0, 32'h0);
    check("alu_dest_mem",     bus.destMEM,      32'd8);
    check("alu_regwrite_mem", bus.regWriteMEM,  32'h1);
    check("alu_result_mem",   bus.ALURESULTMEM, 32'h10);
    tick();
    check("alu_dest_wb",     bus.destWB,      32'd8);
    check("alu_regwrite_wb", bus.regWriteWB,  32'h1);
    check("alu_result_wb",   bus.ALURESULTWB, 32'h10);

    // Load-use right behind lw: two stall cycles, WB carries load data.
    do_reset();
    bus.mem_load_data  = 32'hDEAD_BEEF;
    set_ex(1, 5'd9, 1, 1, 0, 32'h0000_0100);
    bus.id_instruction = instr(6'b000000, 5'd9, 5'd0);
    stalls = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!bus.stall_id) break;
      stalls++;
      tick();
      set_ex(0, 5'd0, 0, 0, 0, 32'h0);
    end
    check("loaduse_stall_cycles", stalls, 32'd2);
    check("loaduse_dest_wb",      bus.destWB,      32'd9);
    check("loaduse_regwrite_wb",  bus.regWriteWB,  32'h1);
    check("loaduse_result_wb",    bus.ALURESULTWB, 32'hDEAD_BEEF);

    // Forced six-cycle hazard: stall_err sets on the fifth stall edge and sticks.
    do_reset();
    set_ex(1, 5'd9, 1, 1, 0, 32'h0000_0200);
    bus.id_instruction = instr(6'b000000, 5'd9, 5'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("err_stall_err_edge%0d", k), bus.stall_err, {31'b0, (k >= 5)});
    end
    set_ex(0, 5'd0, 0, 0, 0, 32'h0);
    bus.id_instruction = 32'h0;
    #1;
    check("err_stall_cleared", bus.stall_id, 32'h0);
    tick();
    check("err_sticky", bus.stall_err, 32'h1);
`ifdef LOAD_HAZARD_STATS_EN
    check("stats_stall_cycles", bus.stall_cycles, 32'd6);
`endif

    // Asynchronous reset mid-stall with loaded slots.
    set_ex(1, 5'd8, 1, 0, 0, 32'h0000_0010);
    tick();
    set_ex(1, 5'd7, 1, 0, 0, 32'h0000_0020);
    tick();
    set_ex(1, 5'd9, 1, 1, 0, 32'h0000_0300);
    bus.id_instruction = instr(6'b000000, 5'd9, 5'd0);
    #1;
    check("rst_pre_stall",    bus.stall_id, 32'h1);
    check("rst_pre_dest_mem", bus.destMEM,  32'd7);
    #2;
    Rst = 1'b1;
    #1;
    check("rst_stall_id",      bus.stall_id,     32'h0);
    check("rst_bubble_ex",     bus.bubble_ex,    32'h0);
    check("rst_stall_err",     bus.stall_err,    32'h0);
    check("rst_dest_mem",      bus.destMEM,      32'h0);
    check("rst_regwrite_mem",  bus.regWriteMEM,  32'h0);
    check("rst_result_mem",    bus.ALURESULTMEM, 32'h0);
    check("rst_dest_wb",       bus.destWB,       32'h0);
    check("rst_regwrite_wb",   bus.regWriteWB,   32'h0);
    check("rst_result_wb",     bus.ALURESULTWB,  32'h0);
`ifdef LOAD_HAZARD_STATS_EN
    check("rst_stall_cycles",  bus.stall_cycles, 32'h0);
`endif
    tick();
    Rst = 1'b0;
    #1;
    check("post_rst_stall_resumes", bus.stall_id, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
